sony_sync_depacket_gen: RTL and testbench

- Parametrised successor to the 8-bit IMX222 depacketiser. Accepts one sensor word per clock carrying Sony embedded sync codes (SAV/EAV) at any word width from 8 to 12 bits.
- Generic horizontal/vertical windowing extracts the active Bayer area.
- Adds per-pixel SOF/EOL markers, line-length checking, lost-sync timeout and error flags.
- Sits between the sub-LVDS deserialiser/word aligner and the Bayer/ISP pipeline.

---
 rtl/sony_sync_depacket_gen.sv | 209 ++++++++++++++++++++
 tb/tb_sony_sync_depacket_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sony_sync_depacket_gen.sv
// sony_sync_depacket_gen: Sony SAV/EAV depacketiser for 8..12-bit sensor words.
// Tracks frames from the embedded sync codes, windows out the active Bayer
// area and flags SOF/EOL, bad line lengths and loss of sync.
module sony_sync_depacket_gen #(
   parameter int DATA_W     = 10,
   parameter int LINE_WORDS = 2000,
   parameter int H_START    = 40,
   parameter int H_ACTIVE   = 1922,
   parameter int V_START    = 23,
   parameter int V_ACTIVE   = 1082,
   parameter int TIMEOUT    = 4095
) (
   input  logic              I_CLK,
   input  logic              I_Rst,
   input  logic [DATA_W-1:0] I_Cmos_Data,
   output logic [DATA_W-1:0] O_Cmos_Pixel,
   output logic              O_Cmos_Vaild,
   output logic              O_SOF,
   output logic              O_EOL,
   output logic              O_Cmos_V_Sync,
   output logic              O_Line_Err,
   output logic              O_Sync_Lost,
   output logic              O_Locked
);

   typedef enum logic [2:0] {HUNT, BLANK, VSYNC, SKIP, ACTIVE} state_t;

   localparam logic [7:0]  XY_SAV_V  = 8'h80;
   localparam logic [7:0]  XY_EAV_V  = 8'h9D;
   localparam logic [7:0]  XY_SAV_I  = 8'hAB;
   localparam logic [7:0]  XY_EAV_I  = 8'hB6;
   localparam logic [15:0] H_FIRST   = 16'(H_START);
   localparam logic [15:0] H_LAST    = 16'(H_START + H_ACTIVE - 1);
   // EAV XY arrives three words after the first EAV word
   localparam logic [15:0] EAV_IDX   = 16'(LINE_WORDS + 3);
   localparam logic [15:0] SKIP_LAST = 16'(V_START - 1);
   localparam logic [15:0] LINE_LAST = 16'(V_ACTIVE - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

   // previous three words; with the current input they form the 4-word code window
   logic [DATA_W-1:0] hist_q [0:2];

   state_t      state_q, state_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [15:0] skip_cnt_q, skip_cnt_d;
   logic [15:0] line_cnt_q, line_cnt_d;
   logic        in_line_q, in_line_d;
   logic        vsync_d, line_err_d, sync_lost_d;

   logic       pre_ok;
   logic [7:0] xy;
   logic       is_vsav, is_veav, is_isav, is_ieav;
   logic       any_sav, any_eav, any_match;
   logic       timeout;
   logic       pix_valid, sof_d, eol_d;

   assign pre_ok    = (hist_q[0] == {DATA_W{1'b1}}) && (hist_q[1] == '0) && (hist_q[2] == '0);
   assign xy        = I_Cmos_Data[DATA_W-1 -: 8];
   assign is_vsav   = pre_ok && (xy == XY_SAV_V);
   assign is_veav   = pre_ok && (xy == XY_EAV_V);
   assign is_isav   = pre_ok && (xy == XY_SAV_I);
   assign is_ieav   = pre_ok && (xy == XY_EAV_I);
   assign any_sav   = is_vsav || is_isav;
   assign any_eav   = is_veav || is_ieav;
   assign any_match = any_sav || any_eav;

   assign timeout   = !any_match && (to_cnt_q == TO_LAST) && (state_q != HUNT);

   // the code word itself is never a pixel, whatever the window says
   assign pix_valid = (state_q == ACTIVE) && in_line_q && !any_match &&
                      (word_cnt_q >= H_FIRST) && (word_cnt_q <= H_LAST);
   assign sof_d     = pix_valid && (line_cnt_q == '0) && (word_cnt_q == H_FIRST);
   assign eol_d     = pix_valid && (word_cnt_q == H_LAST);

   assign O_Locked  = (state_q != HUNT);

   // sync-code history shift register
   // NOTE: the history is reset so a stale all-ones word cannot fake a code right after reset.
   always_ff @(posedge I_CLK) begin
      if (I_Rst) begin
         hist_q[0] <= '0;
         hist_q[1] <= '0;
         hist_q[2] <= '0;
      end else begin
         hist_q[0] <= hist_q[1];
         hist_q[1] <= hist_q[2];
         hist_q[2] <= I_Cmos_Data;
      end
   end

   // next-state, counter and error-pulse logic
   always_comb begin
      // NOTE: every next value defaults to its current value first, so no latch can be inferred.
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      to_cnt_d    = to_cnt_q;
      skip_cnt_d  = skip_cnt_q;
      line_cnt_d  = line_cnt_q;
      in_line_d   = in_line_q;
      vsync_d     = O_Cmos_V_Sync;
      line_err_d  = 1'b0;
      sync_lost_d = 1'b0;

      if (any_sav)
         word_cnt_d = '0;
      else if (!any_match && (word_cnt_q != 16'hFFFF))
         word_cnt_d = word_cnt_q + 16'd1;

      if (is_vsav)
         in_line_d = 1'b1;
      else if (is_isav || any_eav)
         in_line_d = 1'b0;

      if (any_match || timeout)
         to_cnt_d = '0;
      else if (to_cnt_q != TO_LAST)
         to_cnt_d = to_cnt_q + 16'd1;

      if (is_veav && ((state_q == VSYNC) || (state_q == SKIP) || (state_q == ACTIVE)) &&
          (word_cnt_q != EAV_IDX))
         line_err_d = 1'b1;

      if (timeout) begin
         state_d     = HUNT;
         vsync_d     = 1'b0;
         sync_lost_d = 1'b1;
         skip_cnt_d  = '0;
         line_cnt_d  = '0;
      end else begin
         case (state_q)
            HUNT:   if (is_ieav) state_d = BLANK;
            BLANK:  if (is_vsav) begin
                       state_d = VSYNC;
                       vsync_d = 1'b1;
                    end
            VSYNC:  if (is_veav) begin
                       vsync_d    = 1'b0;
                       skip_cnt_d = '0;
                       line_cnt_d = '0;
                       state_d    = (V_START == 0) ? ACTIVE : SKIP;
                    end
            SKIP:   if (is_veav) begin
                       if (skip_cnt_q == SKIP_LAST) begin
                          skip_cnt_d = '0;
                          state_d    = ACTIVE;
                       end else begin
                          skip_cnt_d = skip_cnt_q + 16'd1;
                       end
                    end
            ACTIVE: if (is_isav || is_ieav) begin
                       sync_lost_d = 1'b1;
                       line_cnt_d  = '0;
                       state_d     = BLANK;
                    end else if (is_veav) begin
                       if (line_cnt_q == LINE_LAST) begin
                          line_cnt_d = '0;
                          state_d    = BLANK;
                       end else begin
                          line_cnt_d = line_cnt_q + 16'd1;
                       end
                    end
            default: state_d = HUNT;
         endcase
      end
   end

   // state and counter registers
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge I_CLK) begin
      if (I_Rst) begin
         state_q    <= HUNT;
         word_cnt_q <= '0;
         to_cnt_q   <= '0;
         skip_cnt_q <= '0;
         line_cnt_q <= '0;
         in_line_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         to_cnt_q   <= to_cnt_d;
         skip_cnt_q <= skip_cnt_d;
         line_cnt_q <= line_cnt_d;
         in_line_q  <= in_line_d;
      end
   end

   // registered pixel, marker and status outputs
   always_ff @(posedge I_CLK) begin
      if (I_Rst) begin
         O_Cmos_Pixel  <= '0;
         O_Cmos_Vaild  <= 1'b0;
         O_SOF         <= 1'b0;
         O_EOL         <= 1'b0;
         O_Cmos_V_Sync <= 1'b0;
         O_Line_Err    <= 1'b0;
         O_Sync_Lost   <= 1'b0;
      end else begin
         O_Cmos_Pixel  <= pix_valid ? I_Cmos_Data : '0;
         O_Cmos_Vaild  <= pix_valid;
         O_SOF         <= sof_d;
         O_EOL         <= eol_d;
         O_Cmos_V_Sync <= vsync_d;
         O_Line_Err    <= line_err_d;
         O_Sync_Lost   <= sync_lost_d;
      end
   end

endmodule

// File: tb/tb_sony_sync_depacket_gen.sv
// tb_sony_sync_depacket_gen: directed bench driving a 10-bit and a 12-bit
// depacketiser from the same 12-bit word stream (the 10-bit one sees the top
// ten bits), so code words carry nonzero low bits on both instances.
module tb_sony_sync_depacket_gen;

   localparam int LW = 16, HS = 4, HA = 8, VS = 2, VA = 3, TO = 64, NB = 4;
   localparam logic [7:0] SAV_V = 8'h80, EAV_V = 8'h9D, SAV_I = 8'hAB, EAV_I = 8'hB6;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] din;
   logic [9:0]  din10;
   assign din10 = din[11:2];

   logic [9:0]  pix10;
   logic        vld10, sof10, eol10, vs10, lerr10, slost10, lock10;
   logic [11:0] pix12;
   logic        vld12, sof12, eol12, vs12, lerr12, slost12, lock12;

   // expected status levels / one-shot pulses for the next sampled word
   logic exp_vs, exp_lock, exp_lerr, exp_slost;

   int n_chk, n_fail;
   int n_vld, n_sof, n_eol, n_lerr, n_slost, n_vld12;

   always #5 clk = ~clk;

   sony_sync_depacket_gen #(
      .DATA_W(10), .LINE_WORDS(LW), .H_START(HS), .H_ACTIVE(HA),
      .V_START(VS), .V_ACTIVE(VA), .TIMEOUT(TO)
   ) dut10 (
      .I_CLK(clk), .I_Rst(rst), .I_Cmos_Data(din10),
      .O_Cmos_Pixel(pix10), .O_Cmos_Vaild(vld10), .O_SOF(sof10), .O_EOL(eol10),
      .O_Cmos_V_Sync(vs10), .O_Line_Err(lerr10), .O_Sync_Lost(slost10), .O_Locked(lock10)
   );

   sony_sync_depacket_gen #(
      .DATA_W(12), .LINE_WORDS(LW), .H_START(HS), .H_ACTIVE(HA),
      .V_START(VS), .V_ACTIVE(VA), .TIMEOUT(TO)
   ) dut12 (
      .I_CLK(clk), .I_Rst(rst), .I_Cmos_Data(din),
      .O_Cmos_Pixel(pix12), .O_Cmos_Vaild(vld12), .O_SOF(sof12), .O_EOL(eol12),
      .O_Cmos_V_Sync(vs12), .O_Line_Err(lerr12), .O_Sync_Lost(slost12), .O_Locked(lock12)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] pix_word(input int ln, input int i);
      return 12'(12'h101 + ln * 40 + i * 3);
   endfunction

   // drive one word, then check every output produced for it one clock later
   task automatic put(input logic [11:0] w, input logic v, input logic s, input logic e);
      logic [6:0] exp_f;
      din = w;
      @(posedge clk);
      @(negedge clk);
      exp_f = {v, s, e, exp_vs, exp_lerr, exp_slost, exp_lock};
      check("flags10", {25'd0, vld10, sof10, eol10, vs10, lerr10, slost10, lock10}, {25'd0, exp_f});
      check("flags12", {25'd0, vld12, sof12, eol12, vs12, lerr12, slost12, lock12}, {25'd0, exp_f});
      check("pix10", {22'd0, pix10}, v ? {22'd0, w[11:2]} : 32'd0);
      check("pix12", {20'd0, pix12}, v ? {20'd0, w} : 32'd0);
      n_vld   += int'(vld10);
      n_sof   += int'(sof10);
      n_eol   += int'(eol10);
      n_lerr  += int'(lerr10);
      n_slost += int'(slost10);
      n_vld12 += int'(vld12);
      exp_lerr  = 1'b0;
      exp_slost = 1'b0;
   endtask

   // four-word sync code; expectations given apply from the XY word on
   task automatic code(input logic [7:0] xy, input logic vs, input logic lk,
                       input logic le, input logic sl);
      put(12'hFFF, 1'b0, 1'b0, 1'b0);
      put(12'h000, 1'b0, 1'b0, 1'b0);
      put(12'h000, 1'b0, 1'b0, 1'b0);
      exp_vs = vs; exp_lock = lk; exp_lerr = le; exp_slost = sl;
      put({xy, 4'h5}, 1'b0, 1'b0, 1'b0);
   endtask

   // blanking gap, SAV, n data words, EAV
   task automatic line(input logic [7:0] sav, input logic [7:0] eav, input int n,
                       input logic act, input int ln, input logic vs_s, input logic vs_e,
                       input logic lk_e, input logic le, input logic sl);
      for (int i = 0; i < NB; i++) put(12'h040 + 12'(i), 1'b0, 1'b0, 1'b0);
      code(sav, vs_s, exp_lock, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         logic v;
         v = act && (i >= HS) && (i <= HS + HA - 1);
         put(pix_word(ln, i), v, v && (ln == 0) && (i == HS), v && (i == HS + HA - 1));
      end
      code(eav, vs_e, lk_e, le, sl);
   endtask

   // one frame starting from BLANK: V-sync line, skipped lines, active lines
   task automatic frame(input int bad_len_line, input int abort_line);
      line(SAV_V, EAV_V, LW, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int s = 0; s < VS; s++)
         line(SAV_V, EAV_V, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int l = 0; l < VA; l++) begin
         if (l == abort_line) begin
            line(SAV_V, EAV_I, LW, 1'b1, l, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            return;
         end
         line(SAV_V, EAV_V, (l == bad_len_line) ? LW - 1 : LW, 1'b1, l,
              1'b0, 1'b0, 1'b1, l == bad_len_line, 1'b0);
      end
      line(SAV_I, EAV_I, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic tally(input string tag, input int e_vld, input int e_sof, input int e_eol,
                        input int e_lerr, input int e_slost);
      check({tag, "_pixels"}, n_vld, e_vld);
      check({tag, "_pixels12"}, n_vld12, e_vld);
      check({tag, "_sof"}, n_sof, e_sof);
      check({tag, "_eol"}, n_eol, e_eol);
      check({tag, "_line_err"}, n_lerr, e_lerr);
      check({tag, "_sync_lost"}, n_slost, e_slost);
      n_vld = 0; n_sof = 0; n_eol = 0; n_lerr = 0; n_slost = 0; n_vld12 = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      n_vld = 0; n_sof = 0; n_eol = 0; n_lerr = 0; n_slost = 0; n_vld12 = 0;
      exp_vs = 1'b0; exp_lock = 1'b0; exp_lerr = 1'b0; exp_slost = 1'b0;
      din = '0;

      // reset state
      rst = 1'b1;
      put(12'hFFF, 1'b0, 1'b0, 1'b0);
      put(12'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      put(12'h123, 1'b0, 1'b0, 1'b0);
      put(12'h124, 1'b0, 1'b0, 1'b0);

      // lock on the first invalid EAV
      line(SAV_I, EAV_I, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tally("hunt", 0, 0, 0, 0, 0);

      // clean frame, V-sync timing checked word by word
      frame(-1, -1);
      tally("clean", VA * HA, 1, VA, 0, 0);

      // short active line 1
      frame(1, -1);
      tally("short_line", VA * HA, 1, VA, 1, 0);

      // invalid EAV ends active line 1, then a normal frame
      frame(-1, 1);
      tally("abort", 2 * HA, 1, 2, 0, 1);
      line(SAV_I, EAV_I, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      frame(-1, -1);
      tally("after_abort", VA * HA, 1, VA, 0, 0);

      // no sync code for TIMEOUT words
      for (int k = 1; k <= TO; k++) begin
         if (k == TO) begin
            exp_slost = 1'b1;
            exp_lock  = 1'b0;
         end
         put(12'h554, 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 3; k++) put(12'h554, 1'b0, 1'b0, 1'b0);
      line(SAV_I, EAV_I, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tally("timeout", 0, 0, 0, 0, 1);

      // reset in the middle of active line 0
      line(SAV_V, EAV_V, LW, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int s = 0; s < VS; s++)
         line(SAV_V, EAV_V, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) put(12'h040 + 12'(i), 1'b0, 1'b0, 1'b0);
      code(SAV_V, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         put(pix_word(0, i), i >= HS, i == HS, 1'b0);
      rst = 1'b1;
      exp_lock = 1'b0;
      put(pix_word(0, 6), 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 7; i < LW; i++) put(pix_word(0, i), 1'b0, 1'b0, 1'b0);
      code(EAV_V, 1'b0, 1'b0, 1'b0, 1'b0);
      line(SAV_I, EAV_I, LW, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tally("mid_reset", 2, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
